vga_sync_monitor: RTL
=====================

VGA_SYNC_MONITOR -- requirements
Module: vga_sync_monitor

Interface
REQ-001 SHALL have parameter H_TOTAL, default 800, pixel clocks per line.
REQ-002 SHALL have parameter V_TOTAL, default 525, lines per frame.
REQ-003 SHALL have parameter LOCK_FRAMES, default 2, consecutive good frames required for lock (range 1..7).
REQ-004 SHALL have port i_clk, input, 1, pixel clock; all logic on the rising edge.
REQ-005 SHALL have port i_rst, input, 1, reset: synchronous, active-high.
REQ-006 SHALL have port i_hsync_n, input, 1, horizontal sync, active-low, synchronous to i_clk.
REQ-007 SHALL have port i_vsync_n, input, 1, vertical sync, active-low, synchronous to i_clk.
REQ-008 SHALL have port i_blank_n, input, 1, high during active video.
REQ-009 SHALL have port o_x, output, 10, active pixel column.
REQ-010 SHALL have port o_y, output, 10, active line row.
REQ-011 SHALL have port o_pixel_valid, output, 1, o_x/o_y denote an active pixel while locked.
REQ-012 SHALL have port o_locked, output, 1, timing lock status.
REQ-013 SHALL have port o_frame_start, output, 1, one-cycle pulse at each frame start while locked.
REQ-014 SHALL have port o_line_error, output, 1, one-cycle pulse on a bad line length.
REQ-015 SHALL have port o_frame_error, output, 1, one-cycle pulse on a bad lines-per-frame count.
REQ-016 SHALL have port o_err_count, output, 16, error event counter (see Configuration).

Function
REQ-017 SHALL register previous i_hsync_n, i_vsync_n, i_blank_n; a falling edge is previous=1 and current=0; there is no input synchronizer.
REQ-018 SHALL run h_cnt (10 bit): 0 in the cycle of an hsync falling edge, otherwise +1, saturating at 1023.
REQ-019 SHALL define a line as good when, at an hsync falling edge, the prior h_cnt equals H_TOTAL-1.
REQ-020 SHALL run v_cnt (10 bit): 0 at a vsync falling edge, +1 at each other hsync falling edge, saturating at 1023; a frame is good when the prior v_cnt equals V_TOTAL-1 at a vsync falling edge and every line in that frame was good.
REQ-021 SHALL implement FSM SEARCH, ACQUIRE, LOCKED; reset state is SEARCH.
REQ-022 SEARCH: first vsync falling edge -> ACQUIRE, good-frame count cleared; the partial frame is ignored.
REQ-023 ACQUIRE: at each vsync falling edge, a good frame increments good-frame count and a bad frame -> SEARCH; when the count reaches LOCK_FRAMES -> LOCKED.
REQ-024 LOCKED: a bad line -> o_line_error pulse and SEARCH; a bad frame -> o_frame_error pulse and SEARCH; both in one cycle -> both pulse.
REQ-025 Error pulses SHALL fire only from LOCKED.
REQ-026 o_locked SHALL be high exactly while the state is LOCKED, so it is registered, one cycle after the transition edge.
REQ-027 x counter SHALL +1 each cycle i_blank_n=1 and clear when i_blank_n=0; y counter SHALL +1 at each i_blank_n falling edge and clear at each vsync falling edge; both saturate at 1023.
REQ-028 o_x, o_y, o_pixel_valid SHALL be registered with 1-cycle latency from i_blank_n; o_pixel_valid = delayed i_blank_n AND locked.
REQ-029 o_frame_start SHALL pulse the cycle after a vsync falling edge when the state remains LOCKED.

Reset
REQ-030 While i_rst=1 the block SHALL clear all counters and outputs to 0, set the FSM to SEARCH, and set previous-sample registers to 1 so no spurious edge follows reset.
REQ-031 Reset mid-frame SHALL drop o_locked the next cycle; relock SHALL require the full SEARCH/ACQUIRE sequence.

Configuration
REQ-032 With macro VGA_SYNC_MONITOR_STATS_EN defined, o_err_count SHALL increment by 1 per cycle in which o_line_error or o_frame_error is high; it saturates at 65535 and is cleared only by reset.
REQ-033 Without VGA_SYNC_MONITOR_STATS_EN, o_err_count SHALL be tied to 0 and no counter logic SHALL be built; the port list is unchanged.

Verification
REQ-034 Nominal 640x480 stream (800x525, hsync 96, vsync 2) from reset -> o_locked=1 one cycle after the 3rd vsync falling edge, with no error pulses.
REQ-035 While locked -> first active pixel gives o_x=0, o_y=0, o_pixel_valid=1; last gives o_x=639, o_y=479; o_frame_start pulses once per frame.
REQ-036 While locked, one line stretched to 801 clocks -> o_line_error pulses once at that line's ending hsync edge, o_locked=0 the next cycle, and relock occurs after 2 good frames.
REQ-037 While locked, one frame of 524 lines -> o_frame_error pulses once, o_locked drops, and o_line_error stays 0.
REQ-038 i_rst asserted 1 cycle mid-frame while locked -> all outputs 0 next cycle; relock follows per REQ-034.
REQ-039 With VGA_SYNC_MONITOR_STATS_EN, the REQ-036 and REQ-037 sequence -> o_err_count=2; without the macro -> o_err_count=0.

Source files
------------

// File: rtl/vga_sync_monitor.sv
// vga_sync_monitor
//
// Watches a VGA-style sync stream (active-low hsync/vsync plus blank_n) and
// decides whether it matches the expected raster geometry. Once a configurable
// number of consecutive good frames has been seen the monitor reports lock and
// publishes active-pixel coordinates. Any bad line or bad frame while locked
// raises a one-cycle error pulse and drops back to searching.
//
// Parameters
//   H_TOTAL      pixel clocks per line
//   V_TOTAL      lines per frame
//   LOCK_FRAMES  consecutive good frames required for lock (1..7)
//
// Ports
//   i_clk          pixel clock, rising edge
//   i_rst          synchronous active-high reset
//   i_hsync_n      horizontal sync, active-low, synchronous to i_clk
//   i_vsync_n      vertical sync, active-low, synchronous to i_clk
//   i_blank_n      high during active video
//   o_x, o_y       active pixel column / row (1-cycle latency from i_blank_n)
//   o_pixel_valid  o_x/o_y denote an active pixel while locked
//   o_locked       high while the timing is locked
//   o_frame_start  one-cycle pulse after each vsync falling edge while locked
//   o_line_error   one-cycle pulse on a bad line length while locked
//   o_frame_error  one-cycle pulse on a bad lines-per-frame count while locked
//   o_err_count    error event counter
//
// Build option
//   VGA_SYNC_MONITOR_STATS_EN  when defined, o_err_count counts cycles with an
//                              error pulse (saturating at 65535, cleared only by
//                              reset); otherwise o_err_count is tied to 0.

module vga_sync_monitor #(
  parameter int H_TOTAL     = 800,
  parameter int V_TOTAL     = 525,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_hsync_n,
  input  logic        i_vsync_n,
  input  logic        i_blank_n,
  output logic [9:0]  o_x,
  output logic [9:0]  o_y,
  output logic        o_pixel_valid,
  output logic        o_locked,
  output logic        o_frame_start,
  output logic        o_line_error,
  output logic        o_frame_error,
  output logic [15:0] o_err_count
);

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [2:0] LOCK_N = 3'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  function automatic logic [9:0] sat_inc10(input logic [9:0] v);
    return (v == 10'h3FF) ? v : v + 10'd1;
  endfunction

  // Previous-sample registers for edge detection
  logic hsync_n_p0;
  logic vsync_n_p0;
  logic blank_n_p0;

  logic hs_fall;
  logic vs_fall;
  logic bl_fall;

  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       lines_ok;
  logic       line_bad;
  logic       frame_good;

  state_t     state;
  state_t     state_nxt;
  logic [2:0] good_cnt;
  logic [2:0] good_cnt_nxt;
  logic       line_err_nxt;
  logic       frame_err_nxt;
  logic       frame_start_nxt;

  logic [9:0] x_cnt;
  logic [9:0] y_cnt;
  logic [9:0] x_p1;
  logic [9:0] y_p1;
  logic       vld_p1;

  // ---- stage p0: input history, edge detect ----
  // Reset loads ones so a low sync level right after reset is not an edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      hsync_n_p0 <= 1'b1;
      vsync_n_p0 <= 1'b1;
      blank_n_p0 <= 1'b1;
    end else begin
      hsync_n_p0 <= i_hsync_n;
      vsync_n_p0 <= i_vsync_n;
      blank_n_p0 <= i_blank_n;
    end
  end

  assign hs_fall = hsync_n_p0 & ~i_hsync_n;
  assign vs_fall = vsync_n_p0 & ~i_vsync_n;
  assign bl_fall = blank_n_p0 & ~i_blank_n;

  // h_cnt holds H_TOTAL-1 on the cycle of the next hsync edge when the line
  // has the right length. v_cnt counts hsync edges since the last vsync edge;
  // vsync edges coincide with an hsync edge, which is not counted again.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      h_cnt    <= '0;
      v_cnt    <= '0;
      lines_ok <= 1'b0;
    end else begin
      h_cnt <= hs_fall ? 10'd0 : sat_inc10(h_cnt);
      if (vs_fall)
        v_cnt <= '0;
      else if (hs_fall)
        v_cnt <= sat_inc10(v_cnt);
      if (vs_fall)
        lines_ok <= 1'b1;
      else if (line_bad)
        lines_ok <= 1'b0;
    end
  end

  assign line_bad   = hs_fall && (h_cnt != H_LAST);
  // A line ending on the vsync edge itself still belongs to the closing frame.
  assign frame_good = (v_cnt == V_LAST) && lines_ok && !line_bad;

  // ---- lock FSM ----
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state         <= SEARCH;
      good_cnt      <= '0;
      o_line_error  <= 1'b0;
      o_frame_error <= 1'b0;
      o_frame_start <= 1'b0;
    end else begin
      state         <= state_nxt;
      good_cnt      <= good_cnt_nxt;
      o_line_error  <= line_err_nxt;
      o_frame_error <= frame_err_nxt;
      o_frame_start <= frame_start_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    good_cnt_nxt    = good_cnt;
    line_err_nxt    = 1'b0;
    frame_err_nxt   = 1'b0;
    frame_start_nxt = 1'b0;
    case (state)
      SEARCH: begin
        // The partial frame seen before the first vsync edge is ignored.
        if (vs_fall) begin
          state_nxt    = ACQUIRE;
          good_cnt_nxt = '0;
        end
      end
      ACQUIRE: begin
        if (vs_fall) begin
          if (frame_good) begin
            good_cnt_nxt = good_cnt + 3'd1;
            if (good_cnt_nxt == LOCK_N)
              state_nxt = LOCKED;
          end else begin
            state_nxt    = SEARCH;
            good_cnt_nxt = '0;
          end
        end
      end
      LOCKED: begin
        line_err_nxt  = line_bad;
        frame_err_nxt = vs_fall && !frame_good;
        if (line_err_nxt || frame_err_nxt)
          state_nxt = SEARCH;
        else if (vs_fall)
          frame_start_nxt = 1'b1;
      end
      default: begin
        state_nxt    = SEARCH;
        good_cnt_nxt = '0;
      end
    endcase
  end

  assign o_locked = (state == LOCKED);

  // ---- active-area counters ----
  // x_cnt is the column of the next active pixel; y_cnt the current row.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else begin
      x_cnt <= i_blank_n ? sat_inc10(x_cnt) : 10'd0;
      if (vs_fall)
        y_cnt <= '0;
      else if (bl_fall)
        y_cnt <= sat_inc10(y_cnt);
    end
  end

  // ---- stage p1: registered pixel outputs ----
  // Valid is qualified with the lock state that will be current while it is
  // presented, so it always equals delayed blank_n AND o_locked.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      x_p1   <= '0;
      y_p1   <= '0;
      vld_p1 <= 1'b0;
    end else begin
      x_p1   <= i_blank_n ? x_cnt : 10'd0;
      y_p1   <= y_cnt;
      vld_p1 <= i_blank_n && (state_nxt == LOCKED);
    end
  end

  assign o_x           = x_p1;
  assign o_y           = y_p1;
  assign o_pixel_valid = vld_p1;

`ifdef VGA_SYNC_MONITOR_STATS_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0] err_cnt;

  // One count per cycle with any error pulse, even if both fire together.
  always_ff @(posedge i_clk) begin
    if (i_rst)
      err_cnt <= '0;
    else if (o_line_error || o_frame_error)
      err_cnt <= sat_inc16(err_cnt);
  end

  assign o_err_count = err_cnt;
`else
  assign o_err_count = 16'd0;
`endif

endmodule
